// File: rtl/rng_range_sampler_if.sv
// rng_range_sampler_if
//   Request/result handshake between a consumer and rng_range_sampler.
//   Signals:
//     req       consumer -> sampler  request a new value
//     range_max consumer -> sampler  exclusive upper bound (0 = full range)
//     ack       consumer -> sampler  consumer takes value
//     busy      sampler -> consumer  request in flight
//     valid     sampler -> consumer  value holds a result until ack
//     value     sampler -> consumer  result
//     fallback  sampler -> consumer  result came from the retry-exhausted path
interface rng_range_sampler_if #(
    parameter int unsigned WIDTH = 10
);
    logic             req;
    logic [WIDTH-1:0] range_max;
    logic             ack;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] value;
    logic             fallback;

    modport master (
        output req, range_max, ack,
        input  busy, valid, value, fallback
    );

    modport slave (
        input  req, range_max, ack,
        output busy, valid, value, fallback
    );
endinterface

// File: rtl/rng_range_sampler.sv
// rng_range_sampler
//   Collects WIDTH consecutive LFSR bits into a word and rejection-samples it
//   into [0, range_max). After MAX_TRIES rejected words the result falls back to
//   range_max-1, bounding latency at MAX_TRIES*(WIDTH+1) edges.
//   Ports:
//     clk        system clock
//     rst        asynchronous active-high reset
//     rand_bit_i one fresh LFSR bit per clock
//     bus        slave side of the request/result handshake
module rng_range_sampler #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rand_bit_i,
    rng_range_sampler_if.slave   bus
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK,
        HOLD
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] bound_q;
    logic [CW-1:0]    cnt_q;
    logic [TW-1:0]    tries_q;
    logic [WIDTH-1:0] value_q;
    logic             valid_q;
    logic             fallback_q;
    logic             busy_q;
    logic             in_range;

    always_comb begin
        sh_d     = {sh_q[WIDTH-2:0], rand_bit_i};
        // A zero bound means the full 2^WIDTH range, so every word is accepted.
        in_range = (bound_q == '0) || (sh_q < bound_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            bound_q    <= '0;
            cnt_q      <= '0;
            tries_q    <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            fallback_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        bound_q <= bus.range_max;
                        tries_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (in_range) begin
                        value_q    <= sh_q;
                        valid_q    <= 1'b1;
                        fallback_q <= 1'b0;
                        state_q    <= HOLD;
                    end else if (tries_q == TRY_LAST) begin
                        value_q    <= bound_q - WIDTH'(1);
                        valid_q    <= 1'b1;
                        fallback_q <= 1'b1;
                        state_q    <= HOLD;
                    end else begin
                        // Retry with a completely fresh word; the rejected bits are discarded.
                        tries_q <= tries_q + TW'(1);
                        cnt_q   <= '0;
                        state_q <= COLLECT;
                    end
                end
                HOLD: begin
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.value    = value_q;
    assign bus.fallback = fallback_q;

endmodule

// File: tb/tb_rng_range_sampler.sv
module tb_rng_range_sampler;

    localparam int unsigned W     = 10;
    localparam int unsigned MT    = 8;
    localparam int unsigned EDGES = MT * (W + 1);

    logic clk = 1'b0;
    logic rst;
    logic rand_bit;

    rng_range_sampler_if #(.WIDTH(W)) bus ();

    rng_range_sampler #(
        .WIDTH    (W),
        .MAX_TRIES(MT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rand_bit_i(rand_bit),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Bit presented before edge j after the accept edge (j = 1 .. EDGES).
    bit edge_bits [0:EDGES+16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input bit b);
        for (int i = 0; i <= EDGES + 16; i++) edge_bits[i] = b;
    endtask

    task automatic fill_rand();
        for (int i = 0; i <= EDGES + 16; i++) edge_bits[i] = 1'($urandom);
    endtask

    // Try t reads its word from edges t*(W+1)+1 .. t*(W+1)+W, MSB first;
    // the edge in between is the compare cycle and consumes no bit.
    function automatic void model(input int bound, output int val, output int fb, output int lat);
        for (int t = 0; t < int'(MT); t++) begin
            int w = 0;
            for (int b = 0; b < int'(W); b++)
                w = w * 2 + int'(edge_bits[t * (W + 1) + 1 + b]);
            if (bound == 0 || w < bound) begin
                val = w;
                fb  = 0;
                lat = (t + 1) * (W + 1);
                return;
            end
        end
        val = bound - 1;
        fb  = 1;
        lat = EDGES;
    endfunction

    task automatic do_request(input int bound, input int hold, input string tag);
        int ev, efb, elat, lat;
        model(bound, ev, efb, elat);
        bus.range_max = W'(bound);
        bus.req       = 1'b1;
        tick();
        bus.req       = 1'b0;
        bus.range_max = W'($urandom);
        check({tag, "_busy"}, 32'(bus.busy), 1);
        lat = 0;
        for (int j = 1; j <= int'(EDGES) + 5; j++) begin
            rand_bit = edge_bits[j];
            tick();
            if (bus.valid) begin
                lat = j;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        if (lat == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            return;
        end
        check({tag, "_value"}, 32'(bus.value), 32'(ev));
        check({tag, "_fallback"}, 32'(bus.fallback), 32'(efb));
        for (int h = 0; h < hold; h++) begin
            bus.req       = 1'($urandom);
            bus.range_max = W'($urandom);
            rand_bit      = 1'($urandom);
            tick();
            check({tag, "_hold_valid"}, 32'(bus.valid), 1);
            check({tag, "_hold_value"}, 32'(bus.value), 32'(ev));
            check({tag, "_hold_fb"}, 32'(bus.fallback), 32'(efb));
        end
        // req alongside ack must not start a new request on the same edge.
        bus.req = 1'b1;
        bus.ack = 1'b1;
        tick();
        bus.req = 1'b0;
        bus.ack = 1'b0;
        check({tag, "_ack_valid"}, 32'(bus.valid), 0);
        check({tag, "_ack_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pat;
        rst           = 1'b1;
        rand_bit      = 1'b0;
        bus.req       = 1'b0;
        bus.ack       = 1'b0;
        bus.range_max = '0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_value", 32'(bus.value), 0);
        check("rst_fallback", 32'(bus.fallback), 0);
        rst = 1'b0;
        tick();

        // Full range, fixed pattern.
        fill_const(1'b0);
        pat = 10'h2AA;
        for (int i = 0; i < int'(W); i++) edge_bits[i + 1] = pat[W - 1 - i];
        do_request(0, 2, "t1");

        // One rejection then an accepted small word.
        fill_const(1'b0);
        for (int i = 1; i <= int'(W); i++) edge_bits[i] = 1'b1;
        pat = 10'd5;
        for (int i = 0; i < int'(W); i++) edge_bits[W + 2 + i] = pat[W - 1 - i];
        do_request(600, 1, "t2");

        // All ones: every word rejected, fallback to bound-1.
        fill_const(1'b1);
        do_request(100, 0, "t3");

        // Long hold with req/range_max noise.
        fill_rand();
        do_request(300, 20, "t4");

        // Reset in the middle of collection.
        fill_const(1'b1);
        bus.range_max = '0;
        bus.req       = 1'b1;
        tick();
        bus.req = 1'b0;
        repeat (5) begin
            rand_bit = 1'b1;
            tick();
        end
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(bus.busy), 0);
        check("t5_rst_valid", 32'(bus.valid), 0);
        check("t5_rst_value", 32'(bus.value), 0);
        check("t5_rst_fallback", 32'(bus.fallback), 0);
        tick();
        rst = 1'b0;
        tick();
        fill_rand();
        do_request(0, 0, "t5");

        // range_max=1: only a zero word is acceptable.
        for (int k = 0; k < 6; k++) begin
            fill_rand();
            do_request(1, 0, "t6");
        end

        // Random bounds, including small ones that force rejections.
        for (int k = 0; k < 14; k++) begin
            int bound;
            case ($urandom_range(0, 3))
                0: bound = 0;
                1: bound = int'($urandom_range(1, 40));
                default: bound = int'($urandom_range(1, 1023));
            endcase
            fill_rand();
            do_request(bound, int'($urandom_range(0, 3)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
